calc_key_engine: RTL and testbench
==================================

# calc_key_engine

Parametrised keypad calculator engine. It sits between the `keyboard` decoder (`press`, `scan_code`) and the seven-segment digit drivers, and replaces the fixed 8-bit running-sum buffer and the combinational BCD converter. The block debounces key presses and runs an operand/operator entry state machine for signed add/subtract over `DIGITS` decimal digits. It then converts the displayed magnitude to packed BCD with a sequential double-dabble.

## Interface
- `DIGITS`, 3: number of decimal digits per operand and per result.
- `WIDTH`, 10: binary magnitude width. Must satisfy 2^WIDTH > 10^DIGITS − 1.
- `DEBOUNCE`, 2: number of consecutive equal `press` samples required to accept a press or a release (≥1).

Ports:
- `clk`  in  1: single clock (the divided key clock in the top level).
- `rst`  in  1: synchronous, active-high reset.
- `press`  in  1: key-down level from the decoder.
- `scan_code`  in  4: key code, valid while `press`=1.
- `value_bcd`  out  4*DIGITS: packed BCD magnitude of the displayed value; digit 0 is in bits [3:0].
- `neg`  out  1: displayed value is negative.
- `err`  out  1: overflow error latched.
- `busy`  out  1: BCD conversion in progress.
- `key_ack`  out  1: one-cycle pulse per accepted key.
- `state`  out  2: 0 = S_A, 1 = S_B, 2 = S_R, 3 = S_ERR.

## Operation
- **Debounce:**
  - A key is accepted when `press` has been sampled high for `DEBOUNCE` consecutive cycles while the engine is armed.
  - `scan_code` is captured on that cycle.
  - The engine re-arms only after `DEBOUNCE` consecutive low samples.
  - Each physical press yields exactly one `key_ack`.
- **Key map:**
  - 0x0–0x9: digit.
  - 0xA: add.
  - 0xB: subtract.
  - 0xE: equals.
  - 0xF: clear.
  - 0xC and 0xD: ignored, no state change, but `key_ack` still pulses.
- **Registers:**
  - `a`: signed, WIDTH+1 bits.
  - `b`: unsigned, WIDTH bits.
  - `op`: 1 bit.
  - `a_cnt` and `b_cnt`: digit counters.
- **Digit entry:** `x = x*10 + d`. A digit is ignored when the counter equals `DIGITS`. A leading 0 does not increment the counter.
- **S_A:**
  - digit → updates `a`.
  - add/sub → `op` set, `b` = 0, `b_cnt` = 0, go to S_B.
  - equals → ignored.
- **S_B:**
  - digit → updates `b`.
  - add/sub with `b_cnt` = 0 → replaces `op`.
  - add/sub with `b_cnt` > 0 → `a = a op b`, new `op` stored, `b` cleared, stay in S_B (chaining).
  - equals → if `b_cnt` > 0, `a = a op b`; then go to S_R.
- **S_R:**
  - digit → `a` = d, `a_cnt` = 1, go to S_A.
  - add/sub → uses `a` as the left operand, go to S_B.
  - equals → ignored.
- **Clear (any state):** `a`, `b`, counters and `err` are zeroed; go to S_A.
- **Overflow:** if |a op b| > 10^DIGITS − 1:
  - `err` = 1 and the state goes to S_ERR.
  - `a` is left unchanged.
  - In S_ERR only clear is acted on.
- **Displayed value:**
  - S_B with `b_cnt` > 0 → `b`.
  - otherwise → `a`.
  - In S_ERR, `value_bcd` is held at its last value.
  - `neg` = sign of the displayed value; `neg` is 0 whenever `b` is shown.
- **BCD conversion:**
  - Any change of the displayed magnitude starts a double-dabble of WIDTH shift cycles.
  - A change during a conversion aborts it and restarts with the new value.
  - `value_bcd` is written only when a conversion completes.

## Timing
- Reset values:
  - `value_bcd` = 0, `neg` = 0, `err` = 0, `busy` = 0, `key_ack` = 0, `state` = S_A.
  - Debounce counter = 0, armed.
- Key acceptance: the `DEBOUNCE`-th high sample at edge N produces:
  - `key_ack` high during cycle N+1;
  - `a`, `b`, `op`, `state` and `err` updated at the same edge N+1.
- Conversion:
  - `busy` rises at edge N+2.
  - `busy` is high for exactly WIDTH cycles.
  - `value_bcd` and `neg` update on the edge where `busy` falls, i.e. N+2+WIDTH.
- `press` dropping before `DEBOUNCE` samples: no acceptance, and the counter restarts.
- `rst` asserted mid-conversion or mid-debounce: everything returns to reset values on that edge, and no `key_ack` is issued.

## Test plan
- Reset, keys 1, 2, 3 → `value_bcd` = 0x123. A further key 4 → still 0x123, `key_ack` pulses 4 times in total.
- Keys 1 2 + 3 4 = → `value_bcd` = 0x046, `neg` = 0, `state` = S_R, `busy` low for 10 cycles after completion.
- Keys 5 − 1 2 = → `value_bcd` = 0x007, `neg` = 1. Then key 3 → 0x003, `neg` = 0, S_A.
- Keys 9 9 9 + 1 = → `err` = 1, `state` = 3, display held at 0x001. Key 5 → no change. Key F → `err` = 0, `value_bcd` = 0x000.
- Chaining and operator replace:
  - Keys 7 + 8 − 5 = → display 0x015 after '−', then final 0x010.
  - Keys 9 + − 4 = → 0x005.
- Debounce with `DEBOUNCE` = 2:
  - `press` high for 1 cycle → no `key_ack`.
  - `press` held high for 10 cycles → exactly one `key_ack`.
  - A 1-cycle low glitch mid-hold → no second `key_ack`.

Source files
------------

// File: rtl/calc_key_engine.sv
// calc_key_engine
// Keypad calculator core: debounces key presses from the keypad decoder, runs
// the operand/operator entry machine for signed add/subtract over DIGITS
// decimal digits, and converts the displayed magnitude to packed BCD with a
// sequential double-dabble.
//
// Ports:
//   clk        in   clock (the divided key clock)
//   rst        in   synchronous active-high reset
//   press      in   key-down level from the decoder
//   scan_code  in   [3:0] key code, valid while press is high
//   value_bcd  out  [4*DIGITS-1:0] packed BCD magnitude, digit 0 in [3:0]
//   neg        out  displayed value is negative
//   err        out  overflow error latched
//   busy       out  BCD conversion in progress
//   key_ack    out  one-cycle pulse per accepted key
//   state      out  [1:0] 0=S_A, 1=S_B, 2=S_R, 3=S_ERR
module calc_key_engine #(
   parameter int DIGITS   = 3,
   parameter int WIDTH    = 10,
   parameter int DEBOUNCE = 2
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                press,
   input  logic [3:0]          scan_code,
   output logic [4*DIGITS-1:0] value_bcd,
   output logic                neg,
   output logic                err,
   output logic                busy,
   output logic                key_ack,
   output logic [1:0]          state
);

   function automatic int pow10(input int n);
      int r;
      r = 1;
      for (int i = 0; i < n; i++) r = r * 10;
      return r;
   endfunction

   localparam int BW   = 4 * DIGITS;
   localparam int MAXV = pow10(DIGITS) - 1;
   localparam int CW   = $clog2(DIGITS + 1);
   localparam int DW   = $clog2(DEBOUNCE + 1);
   localparam int SW   = $clog2(WIDTH + 1);

   localparam logic [1:0]    S_A      = 2'd0;
   localparam logic [1:0]    S_B      = 2'd1;
   localparam logic [1:0]    S_R      = 2'd2;
   localparam logic [1:0]    S_ERR    = 2'd3;
   localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE - 1);

   // One double-dabble step: add 3 to every digit above 4, then shift in a bit.
   function automatic logic [BW-1:0] dd_step(input logic [BW-1:0] bcd, input logic bit_in);
      logic [BW-1:0] adj;
      adj = bcd;
      for (int i = 0; i < DIGITS; i++) begin
         if (adj[4*i +: 4] > 4'd4) adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
         else                      adj[4*i +: 4] = adj[4*i +: 4];
      end
      return (adj << 1) | BW'(bit_in);
   endfunction

   // debounce
   logic          r_armed, r_key_pend;
   logic [DW-1:0] r_deb_cnt;
   logic [3:0]    r_key_code;
   // engine; r_a is two's complement, r_b is a plain magnitude
   logic [WIDTH:0]   r_a;
   logic [WIDTH-1:0] r_b;
   logic             r_op, r_err, r_key_ack;
   logic [CW-1:0]    r_a_cnt, r_b_cnt;
   logic [1:0]       r_state;
   // converter
   logic             r_busy, r_dd_neg, r_neg, r_last_neg, r_last_ok;
   logic [SW-1:0]    r_sh_cnt;
   logic [WIDTH-1:0] r_dd_bin, r_last_mag;
   logic [BW-1:0]    r_dd_bcd, r_value_bcd;

   logic             w_is_digit, w_is_op, w_is_eq, w_key_op, w_a_take, w_b_take, w_ovf;
   logic [WIDTH:0]   w_a_entry;
   logic [WIDTH-1:0] w_b_entry, w_a_abs, w_disp_mag;
   logic [WIDTH+1:0] w_lhs, w_rhs, w_res, w_res_mag;
   logic             w_show_b, w_disp_neg, w_start;
   logic [BW-1:0]    w_dd_next;

   assign w_is_digit = (r_key_code <= 4'd9);
   assign w_is_op    = (r_key_code == 4'hA) || (r_key_code == 4'hB);
   assign w_is_eq    = (r_key_code == 4'hE);
   assign w_key_op   = r_key_code[0];   // 0xA -> add (0), 0xB -> subtract (1)

   // A digit is dropped once the operand is full; a leading zero is not counted.
   assign w_a_take  = (r_a_cnt != CW'(DIGITS)) && !((r_a == '0) && (r_key_code == 4'd0));
   assign w_b_take  = (r_b_cnt != CW'(DIGITS)) && !((r_b == '0) && (r_key_code == 4'd0));
   assign w_a_entry = r_a * (WIDTH+1)'(10) + (WIDTH+1)'(r_key_code);
   assign w_b_entry = r_b * WIDTH'(10) + WIDTH'(r_key_code);

   // Two extra bits hold any sum/difference of two in-range operands.
   assign w_lhs     = {r_a[WIDTH], r_a};
   assign w_rhs     = {2'b00, r_b};
   assign w_res     = r_op ? (w_lhs - w_rhs) : (w_lhs + w_rhs);
   assign w_res_mag = w_res[WIDTH+1] ? (~w_res + (WIDTH+2)'(1)) : w_res;
   assign w_ovf     = (w_res_mag > (WIDTH+2)'(MAXV));

   assign w_show_b   = (r_state == S_B) && (r_b_cnt != '0);
   assign w_a_abs    = r_a[WIDTH] ? (~r_a[WIDTH-1:0] + WIDTH'(1)) : r_a[WIDTH-1:0];
   assign w_disp_mag = w_show_b ? r_b : w_a_abs;
   assign w_disp_neg = w_show_b ? 1'b0 : r_a[WIDTH];
   // Sign is part of the trigger so that e.g. 5 -> -5 still refreshes neg.
   assign w_start    = (w_disp_mag != r_last_mag) || (w_disp_neg != r_last_neg) || !r_last_ok;
   assign w_dd_next  = dd_step(r_dd_bcd, r_dd_bin[WIDTH-1]);

   // Press/release debouncer: accept after DEBOUNCE highs, re-arm after DEBOUNCE lows.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_armed    <= 1'b1;
         r_deb_cnt  <= '0;
         r_key_pend <= 1'b0;
         r_key_code <= 4'd0;
      end else begin
         r_key_pend <= 1'b0;
         if (r_armed == press) begin
            if (r_deb_cnt == DEB_LAST) begin
               r_deb_cnt  <= '0;
               r_armed    <= !r_armed;
               r_key_pend <= r_armed;
               if (r_armed) r_key_code <= scan_code;
            end else begin
               r_deb_cnt <= r_deb_cnt + DW'(1);
            end
         end else begin
            r_deb_cnt <= '0;
         end
      end
   end

   // Operand/operator entry machine, advanced once per accepted key.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_a <= '0; r_b <= '0; r_op <= 1'b0; r_a_cnt <= '0; r_b_cnt <= '0;
         r_state <= S_A; r_err <= 1'b0; r_key_ack <= 1'b0;
      end else begin
         r_key_ack <= r_key_pend;
         if (r_key_pend) begin
            if (r_key_code == 4'hF) begin
               r_a <= '0; r_b <= '0; r_a_cnt <= '0; r_b_cnt <= '0;
               r_err <= 1'b0; r_state <= S_A;
            end else begin
               case (r_state)
                  S_A: begin
                     if (w_is_digit) begin
                        if (w_a_take) begin
                           r_a     <= w_a_entry;
                           r_a_cnt <= r_a_cnt + CW'(1);
                        end
                     end else if (w_is_op) begin
                        r_op <= w_key_op; r_b <= '0; r_b_cnt <= '0; r_state <= S_B;
                     end
                  end
                  S_B: begin
                     if (w_is_digit) begin
                        if (w_b_take) begin
                           r_b     <= w_b_entry;
                           r_b_cnt <= r_b_cnt + CW'(1);
                        end
                     end else if (w_is_op) begin
                        if (r_b_cnt == '0) begin
                           r_op <= w_key_op;
                        end else if (w_ovf) begin
                           r_err <= 1'b1; r_state <= S_ERR;
                        end else begin
                           r_a <= w_res[WIDTH:0]; r_op <= w_key_op; r_b <= '0; r_b_cnt <= '0;
                        end
                     end else if (w_is_eq) begin
                        if (r_b_cnt == '0) begin
                           r_state <= S_R;
                        end else if (w_ovf) begin
                           r_err <= 1'b1; r_state <= S_ERR;
                        end else begin
                           r_a <= w_res[WIDTH:0]; r_state <= S_R;
                        end
                     end
                  end
                  S_R: begin
                     if (w_is_digit) begin
                        r_a <= (WIDTH+1)'(r_key_code); r_a_cnt <= CW'(1); r_state <= S_A;
                     end else if (w_is_op) begin
                        r_op <= w_key_op; r_b <= '0; r_b_cnt <= '0; r_state <= S_B;
                     end
                  end
                  default: begin
                  end
               endcase
            end
         end
      end
   end

   // Sequential binary-to-BCD converter; output registers change only on completion.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_busy <= 1'b0; r_sh_cnt <= '0; r_dd_bin <= '0; r_dd_bcd <= '0; r_dd_neg <= 1'b0;
         r_value_bcd <= '0; r_neg <= 1'b0;
         r_last_mag <= '0; r_last_neg <= 1'b0; r_last_ok <= 1'b1;
      end else if (r_state == S_ERR) begin
         // Display is frozen; a conversion caught here is dropped and redone later.
         if (r_busy) begin
            r_busy    <= 1'b0;
            r_last_ok <= 1'b0;
         end
      end else if (w_start) begin
         r_busy     <= 1'b1;
         r_sh_cnt   <= SW'(WIDTH);
         r_dd_bin   <= w_disp_mag;
         r_dd_bcd   <= '0;
         r_dd_neg   <= w_disp_neg;
         r_last_mag <= w_disp_mag;
         r_last_neg <= w_disp_neg;
         r_last_ok  <= 1'b1;
      end else if (r_busy) begin
         r_dd_bin <= r_dd_bin << 1;
         r_dd_bcd <= w_dd_next;
         r_sh_cnt <= r_sh_cnt - SW'(1);
         if (r_sh_cnt == SW'(1)) begin
            r_busy      <= 1'b0;
            r_value_bcd <= w_dd_next;
            r_neg       <= r_dd_neg;
         end
      end
   end

   assign value_bcd = r_value_bcd;
   assign neg       = r_neg;
   assign err       = r_err;
   assign busy      = r_busy;
   assign key_ack   = r_key_ack;
   assign state     = r_state;

endmodule

// File: tb/tb_calc_key_engine.sv
module tb_calc_key_engine;
   localparam int DIGITS   = 3;
   localparam int WIDTH    = 10;
   localparam int DEBOUNCE = 2;
   localparam int MAXV     = 999;

   logic        clk = 1'b0, rst = 1'b1, press = 1'b0;
   logic [3:0]  scan_code = 4'd0;
   logic [11:0] value_bcd;
   logic        neg, err, busy, key_ack;
   logic [1:0]  state;

   calc_key_engine #(.DIGITS(DIGITS), .WIDTH(WIDTH), .DEBOUNCE(DEBOUNCE)) dut (
      .clk(clk), .rst(rst), .press(press), .scan_code(scan_code),
      .value_bcd(value_bcd), .neg(neg), .err(err), .busy(busy),
      .key_ack(key_ack), .state(state)
   );

   always #5 clk = ~clk;

   int n_cmp = 0, n_bad = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // output monitor, sampled on the falling edge
   int   cyc = 0, ack_cnt = 0, n_rise = 0, t_ack = 0, t_busy = 0, cur_run = 0, run_len = 0;
   int   val_at_fall = 0;
   logic busy_q = 1'b0;
   always @(negedge clk) begin
      cyc++;
      if (key_ack === 1'b1) begin ack_cnt++; t_ack = cyc; end
      if (busy === 1'b1 && !busy_q) begin n_rise++; t_busy = cyc; cur_run = 0; end
      if (busy === 1'b1) cur_run++;
      if (busy === 1'b0 && busy_q) begin run_len = cur_run; val_at_fall = int'(value_bcd); end
      busy_q = (busy === 1'b1);
   end

   // calculator reference model (plain integers)
   int m_a, m_b, m_op, m_acnt, m_bcnt, m_st, m_err, m_dmag, m_dneg;

   function automatic int to_bcd(input int v);
      int r = 0;
      for (int i = 0; i < DIGITS; i++) begin r |= (v % 10) << (4*i); v = v / 10; end
      return r;
   endfunction

   function automatic bit takes(input int x, input int cnt, input int d);
      return (cnt < DIGITS) && !(x == 0 && d == 0);
   endfunction

   task automatic model_reset();
      m_a = 0; m_b = 0; m_op = 0; m_acnt = 0; m_bcnt = 0; m_st = 0; m_err = 0;
      m_dmag = 0; m_dneg = 0;
   endtask

   task automatic model_calc();
      int r;
      r = (m_op != 0) ? m_a - m_b : m_a + m_b;
      if (r > MAXV || r < -MAXV) begin m_err = 1; m_st = 3; end
      else m_a = r;
   endtask

   task automatic model_key(input logic [3:0] code);
      int d;
      bit dig, opk;
      d = int'(code);
      dig = (d <= 9);
      opk = (d == 10 || d == 11);
      if (d == 15) begin
         m_a = 0; m_b = 0; m_acnt = 0; m_bcnt = 0; m_err = 0; m_st = 0;
      end else if (m_st == 0) begin
         if (dig) begin if (takes(m_a, m_acnt, d)) begin m_a = m_a*10 + d; m_acnt++; end end
         else if (opk) begin m_op = d - 10; m_b = 0; m_bcnt = 0; m_st = 1; end
      end else if (m_st == 1) begin
         if (dig) begin if (takes(m_b, m_bcnt, d)) begin m_b = m_b*10 + d; m_bcnt++; end end
         else if (opk) begin
            if (m_bcnt == 0) m_op = d - 10;
            else begin
               model_calc();
               if (m_st != 3) begin m_op = d - 10; m_b = 0; m_bcnt = 0; end
            end
         end else if (d == 14) begin
            if (m_bcnt > 0) model_calc();
            if (m_st != 3) m_st = 2;
         end
      end else if (m_st == 2) begin
         if (dig) begin m_a = d; m_acnt = 1; m_st = 0; end
         else if (opk) begin m_op = d - 10; m_b = 0; m_bcnt = 0; m_st = 1; end
      end
      if (m_st != 3) begin
         if (m_st == 1 && m_bcnt > 0) begin m_dmag = m_b; m_dneg = 0; end
         else begin m_dmag = (m_a < 0) ? -m_a : m_a; m_dneg = (m_a < 0) ? 1 : 0; end
      end
   endtask

   // one complete key stroke followed by a settle window, then full check
   task automatic press_key(input logic [3:0] code, input int hold);
      int ack0, pmag, pneg;
      pmag = m_dmag; pneg = m_dneg; ack0 = ack_cnt;
      n_rise = 0; t_ack = -100; t_busy = -200; run_len = -1;
      @(negedge clk); press = 1'b1; scan_code = code;
      repeat (hold) @(negedge clk);
      press = 1'b0;
      repeat (DEBOUNCE + WIDTH + 8) @(negedge clk);
      model_key(code);
      chk($sformatf("ack_count[%h]", code), ack_cnt - ack0, 1);
      if (m_dmag != pmag || m_dneg != pneg) begin
         chk("busy_latency", t_busy - t_ack, 1);
         chk("busy_length", run_len, WIDTH);
         chk("bcd_at_busy_fall", val_at_fall, to_bcd(m_dmag));
      end else begin
         chk("no_conversion", n_rise, 0);
      end
      chk($sformatf("value_bcd[%h]", code), value_bcd, to_bcd(m_dmag));
      chk("neg", neg, m_dneg);
      chk("err", err, m_err);
      chk("state", state, m_st);
   endtask

   // press n keys given as hex nibbles, most significant first
   task automatic kseq(input logic [31:0] codes, input int n);
      for (int i = n - 1; i >= 0; i--)
         press_key(codes[4*i +: 4], DEBOUNCE + int'($urandom_range(0, 3)));
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: observed timeout, expected completion");
      $fatal(1);
   end

   initial begin
      int ack0, hi, k, r;
      logic [3:0] code;
      model_reset();
      repeat (3) @(negedge clk);
      chk("rst_value_bcd", value_bcd, 12'h000);
      chk("rst_neg", neg, 1'b0);
      chk("rst_err", err, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_key_ack", key_ack, 1'b0);
      chk("rst_state", state, 2'd0);
      rst = 1'b0;

      ack0 = ack_cnt;
      kseq(32'h123, 3);
      chk("entry_123", value_bcd, 12'h123);
      kseq(32'h4, 1);
      chk("entry_full", value_bcd, 12'h123);
      chk("entry_acks", ack_cnt - ack0, 4);

      kseq(32'hF12A34E, 7);
      chk("add_value", value_bcd, 12'h046);
      chk("add_neg", neg, 1'b0);
      chk("add_state", state, 2'd2);
      hi = 0;
      repeat (10) begin @(negedge clk); if (busy) hi++; end
      chk("add_idle_busy", hi, 0);

      kseq(32'hF5B12E, 6);
      chk("sub_value", value_bcd, 12'h007);
      chk("sub_neg", neg, 1'b1);
      kseq(32'h3, 1);
      chk("new_entry_value", value_bcd, 12'h003);
      chk("new_entry_neg", neg, 1'b0);
      chk("new_entry_state", state, 2'd0);

      kseq(32'hF999A1E, 7);
      chk("ovf_err", err, 1'b1);
      chk("ovf_state", state, 2'd3);
      chk("ovf_held", value_bcd, 12'h001);
      kseq(32'h5, 1);
      chk("ovf_ignore", value_bcd, 12'h001);
      kseq(32'hF, 1);
      chk("clr_err", err, 1'b0);
      chk("clr_value", value_bcd, 12'h000);

      kseq(32'h7A8B, 4);
      chk("chain_mid", value_bcd, 12'h015);
      kseq(32'h5E, 2);
      chk("chain_final", value_bcd, 12'h010);
      kseq(32'hF9AB4E, 6);
      chk("op_replace", value_bcd, 12'h005);

      // press too short to be accepted
      ack0 = ack_cnt;
      @(negedge clk); press = 1'b1; scan_code = 4'h1;
      @(negedge clk); press = 1'b0;
      repeat (WIDTH + 8) @(negedge clk);
      chk("short_press_acks", ack_cnt - ack0, 0);
      chk("short_press_value", value_bcd, to_bcd(m_dmag));

      // long hold yields one key
      ack0 = ack_cnt;
      @(negedge clk); press = 1'b1; scan_code = 4'hC;
      repeat (10) @(negedge clk);
      press = 1'b0;
      repeat (WIDTH + 8) @(negedge clk);
      chk("long_hold_acks", ack_cnt - ack0, 1);

      // one-cycle low glitch during a hold
      ack0 = ack_cnt;
      @(negedge clk); press = 1'b1; scan_code = 4'hD;
      repeat (5) @(negedge clk);
      press = 1'b0;
      @(negedge clk); press = 1'b1;
      repeat (5) @(negedge clk);
      press = 1'b0;
      repeat (WIDTH + 8) @(negedge clk);
      chk("glitch_acks", ack_cnt - ack0, 1);

      // reset during a conversion
      kseq(32'hF12, 3);
      @(negedge clk); press = 1'b1; scan_code = 4'h3;
      repeat (DEBOUNCE) @(negedge clk);
      press = 1'b0;
      k = 0;
      while (busy !== 1'b1 && k < 20) begin @(negedge clk); k++; end
      chk("conv_started", busy, 1'b1);
      rst = 1'b1;
      @(negedge clk);
      chk("midconv_rst_value", value_bcd, 12'h000);
      chk("midconv_rst_busy", busy, 1'b0);
      chk("midconv_rst_state", state, 2'd0);
      rst = 1'b0;
      model_reset();
      repeat (WIDTH + 4) @(negedge clk);
      chk("after_rst_value", value_bcd, 12'h000);
      chk("after_rst_busy", busy, 1'b0);

      // reset on the cycle a key was accepted: no ack, no effect
      ack0 = ack_cnt;
      @(negedge clk); press = 1'b1; scan_code = 4'h5;
      repeat (DEBOUNCE) @(negedge clk);
      rst = 1'b1; press = 1'b0;
      @(negedge clk); rst = 1'b0;
      repeat (WIDTH + 6) @(negedge clk);
      chk("rst_accept_acks", ack_cnt - ack0, 0);
      chk("rst_accept_value", value_bcd, 12'h000);

      // reset mid-debounce restarts the sample count
      ack0 = ack_cnt;
      @(negedge clk); press = 1'b1; scan_code = 4'h6;
      @(negedge clk); rst = 1'b1;
      @(negedge clk); rst = 1'b0;
      @(negedge clk); press = 1'b0;
      repeat (WIDTH + 6) @(negedge clk);
      chk("rst_debounce_acks", ack_cnt - ack0, 0);
      chk("rst_debounce_state", state, 2'd0);
      model_reset();

      // randomized key streams against the model
      repeat (160) begin
         r = int'($urandom_range(0, 99));
         if (r < 55)      code = 4'($urandom_range(0, 9));
         else if (r < 70) code = 4'hA;
         else if (r < 80) code = 4'hB;
         else if (r < 90) code = 4'hE;
         else if (r < 94) code = (r[0]) ? 4'hC : 4'hD;
         else             code = 4'hF;
         press_key(code, DEBOUNCE + int'($urandom_range(0, 3)));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
